dbus_interconnect: RTL and testbench

Parametrised data-bus interconnect between the RISC-V core's split read/write data port and NSLV memory-mapped slaves (IRAM port B, DRAM, UART, future peripherals). It replaces the fixed three-slave decoder and registered read mux with a generic address decoder and a read-response tracker. The tracker adds variable-latency slaves (per-slave rvalid), a CPU stall, a read timeout, and sticky bus-error capture for unmapped accesses.

---
 rtl/dbus_interconnect.sv | 175 +++++++++++++++++
 tb/tb_dbus_interconnect.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_interconnect.sv
// Data-bus interconnect: address decode of the CPU read/write port onto NSLV slaves, plus a
// read-response tracker with stall, timeout and sticky bus-error capture.
module dbus_interconnect #(
  parameter int unsigned        NSLV       = 3,
  parameter logic [31:0]        BASE_MASK  = 32'hFF00_0000,
  parameter logic [NSLV*32-1:0] BASE_ADDRS = {32'h0200_0000, 32'h0100_0000, 32'h0000_0000},
  parameter int unsigned        TIMEOUT    = 16,
  parameter logic [31:0]        ERR_RDATA  = 32'hDEAD_BEEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 dmem_wr,
  input  logic [31:0]          dmem_waddr,
  input  logic [31:0]          dmem_wdata,
  input  logic [3:0]           dmem_wstrb,
  input  logic                 dmem_rd,
  input  logic [31:0]          dmem_raddr,
  output logic [31:0]          dmem_rdata,
  output logic                 stall,
  output logic [NSLV-1:0]      s_wr,
  output logic [31:0]          s_waddr,
  output logic [31:0]          s_wdata,
  output logic [3:0]           s_wstrb,
  output logic [NSLV-1:0]      s_rd,
  output logic [31:0]          s_raddr,
  input  logic [NSLV*32-1:0]   s_rdata,
  input  logic [NSLV-1:0]      s_rvalid,
  input  logic                 err_clr,
  output logic                 err_irq,
  output logic [1:0]           err_type,
  output logic [31:0]          err_addr
);

  localparam int unsigned     SelW    = $clog2(NSLV + 1);
  localparam logic [SelW-1:0] SelMiss = SelW'(NSLV);
  localparam logic [7:0]      CntMax  = 8'(TIMEOUT);

  typedef enum logic {StIdle, StWait} state_e;

  state_e          state_q, state_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [31:0]     raddr_q, raddr_d;
  logic            err_irq_q, err_irq_d;
  logic [1:0]      err_type_q, err_type_d;
  logic [31:0]     err_addr_q, err_addr_d;

  logic [SelW-1:0] rsel, wsel;
  logic            rvalid_sel, sel_miss, timed_out, in_wait, resp, accept;
  logic [31:0]     rdata_sel;
  logic            ev_valid;
  logic [1:0]      ev_type;
  logic [31:0]     ev_addr;

  // Scanning from the top down lets the lowest matching index win on overlapping bases.
  function automatic logic [SelW-1:0] decode(input logic [31:0] addr);
    logic [SelW-1:0] idx;
    idx = SelMiss;
    for (int i = int'(NSLV) - 1; i >= 0; i--) begin
      if ((addr & BASE_MASK) == BASE_ADDRS[32*i +: 32]) idx = SelW'(i);
    end
    return idx;
  endfunction

  always_comb begin
    rsel       = decode(dmem_raddr);
    wsel       = decode(dmem_waddr);
    rvalid_sel = 1'b0;
    rdata_sel  = '0;
    for (int i = 0; i < int'(NSLV); i++) begin
      if (sel_q == SelW'(i)) begin
        rvalid_sel = s_rvalid[i];
        rdata_sel  = s_rdata[32*i +: 32];
      end
    end
    in_wait   = (state_q == StWait);
    sel_miss  = (sel_q == SelMiss);
    timed_out = (cnt_q == CntMax);
    resp      = sel_miss | rvalid_sel | timed_out;
    accept    = ~in_wait | resp;
    stall     = in_wait & ~resp;
  end

  always_comb begin
    for (int i = 0; i < int'(NSLV); i++) begin
      s_wr[i] = dmem_wr & accept & (wsel == SelW'(i));
      s_rd[i] = dmem_rd & accept & (rsel == SelW'(i));
    end
    s_waddr = dmem_waddr & ~BASE_MASK;
    s_raddr = dmem_raddr & ~BASE_MASK;
    s_wdata = dmem_wdata;
    s_wstrb = dmem_wstrb;
  end

  always_comb begin
    dmem_rdata = '0;
    if (in_wait && rvalid_sel) begin
      dmem_rdata = rdata_sel;
    end else if (in_wait && (sel_miss || timed_out)) begin
      dmem_rdata = ERR_RDATA;
    end
  end

  // A write miss outranks a read error in the same cycle.
  always_comb begin
    ev_valid = 1'b0;
    ev_type  = 2'b00;
    ev_addr  = '0;
    if (dmem_wr && accept && (wsel == SelMiss)) begin
      ev_valid = 1'b1;
      ev_type  = 2'b10;
      ev_addr  = dmem_waddr;
    end else if (in_wait && resp && !rvalid_sel) begin
      ev_valid = 1'b1;
      ev_type  = sel_miss ? 2'b01 : 2'b11;
      ev_addr  = raddr_q;
    end

    err_irq_d  = err_irq_q;
    err_type_d = err_type_q;
    err_addr_d = err_addr_q;
    if (err_clr) begin
      err_irq_d  = 1'b0;
      err_type_d = 2'b00;
      err_addr_d = '0;
    end
    if (ev_valid && (!err_irq_q || err_clr)) begin
      err_irq_d  = 1'b1;
      err_type_d = ev_type;
      err_addr_d = ev_addr;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    raddr_d = raddr_q;
    if (dmem_rd && accept) begin
      state_d = StWait;
      sel_d   = rsel;
      cnt_d   = 8'd1;
      raddr_d = dmem_raddr;
    end else if (in_wait && resp) begin
      state_d = StIdle;
    end else if (in_wait) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      cnt_q      <= '0;
      raddr_q    <= '0;
      err_irq_q  <= 1'b0;
      err_type_q <= 2'b00;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      raddr_q    <= raddr_d;
      err_irq_q  <= err_irq_d;
      err_type_q <= err_type_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err_irq  = err_irq_q;
  assign err_type = err_type_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_dbus_interconnect.sv
// Bench for dbus_interconnect: transaction-level model compared every cycle, directed scenarios
// with literal expectations, then randomized traffic with variable slave latency.
module tb_dbus_interconnect;

  localparam int          NS  = 3;
  localparam int          TMO = 16;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          dmem_wr, dmem_rd, err_clr;
  logic [31:0]   dmem_waddr, dmem_wdata, dmem_raddr;
  logic [3:0]    dmem_wstrb;
  logic [31:0]   dmem_rdata, s_waddr, s_wdata, s_raddr, err_addr;
  logic          stall, err_irq;
  logic [1:0]    err_type;
  logic [NS-1:0] s_wr, s_rd, s_rvalid;
  logic [3:0]    s_wstrb;
  logic [NS*32-1:0] s_rdata;

  logic [31:0]   o_rdata, o_waddr, o_wdata, o_raddr, o_eaddr;
  logic          o_stall, o_irq;
  logic [1:0]    o_etype;
  logic [NS-1:0] o_wr, o_rd;
  logic [3:0]    o_wstrb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dbus_interconnect u_dut (
    .clk(clk), .rstn(rstn),
    .dmem_wr(dmem_wr), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rd(dmem_rd), .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata), .stall(stall),
    .s_wr(s_wr), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rd(s_rd), .s_raddr(s_raddr), .s_rdata(s_rdata), .s_rvalid(s_rvalid),
    .err_clr(err_clr), .err_irq(err_irq), .err_type(err_type), .err_addr(err_addr)
  );

  // Slaves 0 and 1 share a base here.
  dbus_interconnect #(
    .BASE_ADDRS({32'h0200_0000, 32'h0100_0000, 32'h0100_0000})
  ) u_ovl (
    .clk(clk), .rstn(rstn),
    .dmem_wr(dmem_wr), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rd(dmem_rd), .dmem_raddr(dmem_raddr), .dmem_rdata(o_rdata), .stall(o_stall),
    .s_wr(o_wr), .s_waddr(o_waddr), .s_wdata(o_wdata), .s_wstrb(o_wstrb),
    .s_rd(o_rd), .s_raddr(o_raddr), .s_rdata(s_rdata), .s_rvalid(s_rvalid),
    .err_clr(err_clr), .err_irq(o_irq), .err_type(o_etype), .err_addr(o_eaddr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Default map: top address byte 0,1,2 selects slave 0,1,2; anything else is unmapped.
  function automatic int slave_of(input logic [31:0] a);
    return (a[31:24] < 8'd3) ? int'(a[31:24]) : -1;
  endfunction

  // Model: at most one outstanding read, tracked by target slave and age in cycles.
  bit          m_pend = 0, n_pend = 0;
  int          m_tgt = 0, n_tgt = 0, m_age = 0, n_age = 0;
  logic [31:0] m_paddr = '0, n_paddr = '0;
  logic        m_irq = 0, n_irq = 0;
  logic [1:0]  m_type = '0, n_type = '0;
  logic [31:0] m_eaddr = '0, n_eaddr = '0;

  int          ri, wi;
  bit          rv, resp, acc, ev;
  logic [1:0]  et;
  logic [31:0] ea, e_rdata;
  logic [NS-1:0] e_rd, e_wr;

  always @(negedge clk) begin
    ri = slave_of(dmem_raddr);
    wi = slave_of(dmem_waddr);
    rv = 0;
    if (m_pend && m_tgt >= 0) rv = s_rvalid[m_tgt];
    resp = m_pend && (m_tgt < 0 || rv || m_age == TMO);
    acc  = !m_pend || resp;
    e_rdata = '0;
    if (resp) e_rdata = rv ? s_rdata[m_tgt*32 +: 32] : ERR;
    e_rd = '0;
    e_wr = '0;
    if (dmem_rd && acc && ri >= 0) e_rd[ri] = 1'b1;
    if (dmem_wr && acc && wi >= 0) e_wr[wi] = 1'b1;

    chk("stall", 32'(stall), 32'(m_pend && !resp));
    chk("rdata", dmem_rdata, e_rdata);
    chk("s_rd", 32'(s_rd), 32'(e_rd));
    chk("s_wr", 32'(s_wr), 32'(e_wr));
    chk("s_raddr", s_raddr, {8'h00, dmem_raddr[23:0]});
    chk("s_waddr", s_waddr, {8'h00, dmem_waddr[23:0]});
    chk("s_wdata", s_wdata, dmem_wdata);
    chk("s_wstrb", 32'(s_wstrb), 32'(dmem_wstrb));
    chk("err_irq", 32'(err_irq), 32'(m_irq));
    chk("err_type", 32'(err_type), 32'(m_type));
    chk("err_addr", err_addr, m_eaddr);

    ev = 0;
    et = '0;
    ea = '0;
    if (dmem_wr && acc && wi < 0) begin
      ev = 1; et = 2'b10; ea = dmem_waddr;
    end else if (resp && !rv) begin
      ev = 1; et = (m_tgt < 0) ? 2'b01 : 2'b11; ea = m_paddr;
    end
    n_irq = m_irq; n_type = m_type; n_eaddr = m_eaddr;
    if (err_clr) begin
      n_irq = 0; n_type = '0; n_eaddr = '0;
    end
    if (ev && (!m_irq || err_clr)) begin
      n_irq = 1; n_type = et; n_eaddr = ea;
    end
    n_pend = m_pend; n_tgt = m_tgt; n_age = m_age; n_paddr = m_paddr;
    if (dmem_rd && acc) begin
      n_pend = 1; n_tgt = ri; n_age = 1; n_paddr = dmem_raddr;
    end else if (resp) begin
      n_pend = 0;
    end else if (m_pend) begin
      n_age = m_age + 1;
    end
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_pend <= 0; m_tgt <= 0; m_age <= 0; m_paddr <= '0;
      m_irq <= 0; m_type <= '0; m_eaddr <= '0;
    end else begin
      m_pend <= n_pend; m_tgt <= n_tgt; m_age <= n_age; m_paddr <= n_paddr;
      m_irq <= n_irq; m_type <= n_type; m_eaddr <= n_eaddr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    dmem_wr = 0; dmem_rd = 0; err_clr = 0; s_rvalid = '0;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 4);
    if (r < 3) return {8'(r), 24'($urandom & 32'h0000_FFFC)};
    return {8'($urandom_range(3, 255)), 24'($urandom)};
  endfunction

  initial begin
    dmem_waddr = '0; dmem_wdata = '0; dmem_wstrb = '0; dmem_raddr = '0; s_rdata = '0;
    idle_in();
    #2;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_rdata", dmem_rdata, 32'h0);
    chk("rst_irq", 32'(err_irq), 32'h0);
    chk("rst_type", 32'(err_type), 32'h0);
    chk("rst_eaddr", err_addr, 32'h0);
    repeat (2) tick();
    rstn = 1;

    // Single-cycle DRAM read.
    tick(); dmem_rd = 1; dmem_raddr = 32'h0100_0010; #1;
    chk("t1_srd", 32'(s_rd), 32'h2);
    chk("t1_raddr", s_raddr, 32'h10);
    chk("t1_stall0", 32'(stall), 32'h0);
    tick(); dmem_rd = 0; s_rvalid = 3'b010; s_rdata[63:32] = 32'h1234_5678; #1;
    chk("t1_rdata", dmem_rdata, 32'h1234_5678);
    chk("t1_stall1", 32'(stall), 32'h0);
    tick(); idle_in();

    // UART read with 3-cycle latency; DRAM write held through the stall.
    tick(); dmem_rd = 1; dmem_raddr = 32'h0200_0000; #1;
    tick(); dmem_rd = 0; dmem_wr = 1; dmem_waddr = 32'h0100_0008; #1;
    chk("t2_stall1", 32'(stall), 32'h1);
    chk("t2_swr1", 32'(s_wr), 32'h0);
    tick(); #1;
    chk("t2_stall2", 32'(stall), 32'h1);
    chk("t2_swr2", 32'(s_wr), 32'h0);
    tick(); s_rvalid = 3'b100; s_rdata[95:64] = 32'hCAFE_0001; #1;
    chk("t2_rdata", dmem_rdata, 32'hCAFE_0001);
    chk("t2_stall3", 32'(stall), 32'h0);
    chk("t2_swr3", 32'(s_wr), 32'h2);
    tick(); idle_in();

    // Timeout on UART.
    tick(); dmem_rd = 1; dmem_raddr = 32'h0200_0004; #1;
    for (int k = 1; k < TMO; k++) begin
      tick(); dmem_rd = 0; #1;
      chk("t3_stall", 32'(stall), 32'h1);
    end
    tick(); #1;
    chk("t3_rdata", dmem_rdata, ERR);
    chk("t3_stall_end", 32'(stall), 32'h0);
    tick(); s_rvalid = 3'b100; s_rdata[95:64] = 32'h1111_1111; #1;
    chk("t3_late", dmem_rdata, 32'h0);
    chk("t3_irq", 32'(err_irq), 32'h1);
    chk("t3_type", 32'(err_type), 32'h3);
    chk("t3_eaddr", err_addr, 32'h0200_0004);
    tick(); s_rvalid = '0; err_clr = 1; #1;
    tick(); err_clr = 0; #1;
    chk("t3_clr", 32'(err_irq), 32'h0);

    // Write miss, then read miss that must not overwrite the first error.
    tick(); dmem_wr = 1; dmem_waddr = 32'h0500_0000; #1;
    chk("t4_swr", 32'(s_wr), 32'h0);
    tick(); dmem_wr = 0; dmem_rd = 1; dmem_raddr = 32'h0600_0000; #1;
    chk("t4_type", 32'(err_type), 32'h2);
    chk("t4_eaddr", err_addr, 32'h0500_0000);
    chk("t4_srd", 32'(s_rd), 32'h0);
    tick(); dmem_rd = 0; #1;
    chk("t4_rdata", dmem_rdata, ERR);
    chk("t4_stall", 32'(stall), 32'h0);
    tick(); #1;
    chk("t4_type_kept", 32'(err_type), 32'h2);
    chk("t4_eaddr_kept", err_addr, 32'h0500_0000);
    tick(); err_clr = 1; #1;
    tick(); err_clr = 0; #1;
    chk("t4_clr_irq", 32'(err_irq), 32'h0);
    chk("t4_clr_type", 32'(err_type), 32'h0);
    chk("t4_clr_addr", err_addr, 32'h0);

    // Overlapping bases.
    tick(); dmem_rd = 1; dmem_raddr = 32'h0100_0000; #1;
    chk("t5_ovl_srd", 32'(o_rd), 32'h1);
    tick(); dmem_rd = 0; s_rvalid = 3'b011; #1;
    tick(); idle_in();

    // Reset in the middle of a wait.
    tick(); dmem_rd = 1; dmem_raddr = 32'h0200_0000; #1;
    tick(); dmem_rd = 0; #1;
    chk("t6_stall_pre", 32'(stall), 32'h1);
    #1; rstn = 0; #1;
    chk("t6_stall_rst", 32'(stall), 32'h0);
    chk("t6_rdata_rst", dmem_rdata, 32'h0);
    tick(); rstn = 1; dmem_rd = 1; dmem_raddr = 32'h0000_0040; #1;
    chk("t6_srd", 32'(s_rd), 32'h1);
    tick(); dmem_rd = 0; s_rvalid = 3'b001; s_rdata[31:0] = 32'hA5A5_0001; #1;
    chk("t6_rdata", dmem_rdata, 32'hA5A5_0001);
    tick(); idle_in();

    // Random traffic: slow slaves first (frequent timeouts), then faster ones.
    for (int c = 0; c < 3000; c++) begin
      int pct;
      tick();
      pct = (c < 1500) ? 4 : 40;
      dmem_rd    = ($urandom_range(0, 1) == 1);
      dmem_raddr = rand_addr();
      dmem_wr    = ($urandom_range(0, 2) == 0);
      dmem_waddr = rand_addr();
      dmem_wdata = $urandom;
      dmem_wstrb = 4'($urandom);
      err_clr    = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < NS; i++) begin
        s_rvalid[i]         = ($urandom_range(0, 99) < pct);
        s_rdata[i*32 +: 32] = $urandom;
      end
    end
    tick(); idle_in();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
